// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin owner of the shared TX DPRAM write port and IP-layer send interface.
// Optional ownership watchdog is built when UDP_TX_ARB_TIMEOUT_EN is defined.
module udp_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   output logic [NUM_REQ-1:0]    gnt,
   input  logic [NUM_REQ-1:0]    req_wrRAM,
   input  logic [8*NUM_REQ-1:0]  req_wrData,
   input  logic [11*NUM_REQ-1:0] req_wrAddr,
   input  logic [NUM_REQ-1:0]    req_sendDatagram,
   input  logic [16*NUM_REQ-1:0] req_dgramSize,
   input  logic [32*NUM_REQ-1:0] req_destIP,
   input  logic [8*NUM_REQ-1:0]  req_protocol,
   input  logic                  tx_done_MAC,
   output logic [NUM_REQ-1:0]    req_tx_done,
   output logic                  wrRAM,
   output logic [7:0]            wrData,
   output logic [10:0]           wrAddr,
   output logic                  sendDatagram,
   output logic [15:0]           sendDatagramSize,
   output logic [31:0]           destinationIP,
   output logic [7:0]            protocolOut,
   output logic                  arb_timeout
);

   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 11;
   localparam int unsigned SW  = 16;
   localparam int unsigned IPW = 32;
   localparam int unsigned PW  = 8;
   localparam int unsigned OW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT_DONE,
      S_RELEASE
   } state_t;

   state_t state, state_nxt;

   logic [OW-1:0]      owner, owner_nxt;
   logic [OW-1:0]      last, last_nxt;
   logic [OW-1:0]      sel_c;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic [NUM_REQ-1:0] req_tx_done_nxt;
   logic               wr_ram_nxt;
   logic [DW-1:0]      wr_data_nxt;
   logic [AW-1:0]      wr_addr_nxt;
   logic               send_nxt;
   logic [SW-1:0]      size_nxt;
   logic [IPW-1:0]     ip_nxt;
   logic [PW-1:0]      proto_nxt;
   logic               timeout_nxt;
   logic               timeout_c;
   logic               busy_c;

   // Per-requester views of the flattened input buses
   logic [DW-1:0]  wr_data_a [NUM_REQ];
   logic [AW-1:0]  wr_addr_a [NUM_REQ];
   logic [SW-1:0]  size_a    [NUM_REQ];
   logic [IPW-1:0] ip_a      [NUM_REQ];
   logic [PW-1:0]  proto_a   [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign wr_data_a[g] = req_wrData[DW*g +: DW];
      assign wr_addr_a[g] = req_wrAddr[AW*g +: AW];
      assign size_a[g]    = req_dgramSize[SW*g +: SW];
      assign ip_a[g]      = req_destIP[IPW*g +: IPW];
      assign proto_a[g]   = req_protocol[PW*g +: PW];
   end

   assign busy_c = (state == S_GRANT) || (state == S_WAIT_DONE);

   // Round-robin pick: first set request after the last owner, wrapping
   always_comb begin
      int unsigned j;
      logic        found;
      sel_c = last;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         j = 32'(last) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[OW'(j)]) begin
            sel_c = OW'(j);
            found = 1'b1;
         end
      end
   end

`ifdef UDP_TX_ARB_TIMEOUT_EN
   localparam int unsigned CW = 16;
   logic [CW-1:0] wd_cnt;

   // Watchdog restarts every ownership; it is held at zero while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                wd_cnt <= '0;
      else if (state == S_IDLE) wd_cnt <= '0;
      else if (busy_c)          wd_cnt <= wd_cnt + CW'(1);
   end

   assign timeout_c = busy_c && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES) | busy_c;
   assign timeout_c          = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         owner            <= '0;
         last             <= OW'(NUM_REQ - 1);
         gnt              <= '0;
         req_tx_done      <= '0;
         wrRAM            <= 1'b0;
         wrData           <= '0;
         wrAddr           <= '0;
         sendDatagram     <= 1'b0;
         sendDatagramSize <= '0;
         destinationIP    <= '0;
         protocolOut      <= '0;
         arb_timeout      <= 1'b0;
      end else begin
         state            <= state_nxt;
         owner            <= owner_nxt;
         last             <= last_nxt;
         gnt              <= gnt_nxt;
         req_tx_done      <= req_tx_done_nxt;
         wrRAM            <= wr_ram_nxt;
         wrData           <= wr_data_nxt;
         wrAddr           <= wr_addr_nxt;
         sendDatagram     <= send_nxt;
         sendDatagramSize <= size_nxt;
         destinationIP    <= ip_nxt;
         protocolOut      <= proto_nxt;
         arb_timeout      <= timeout_nxt;
      end
   end

   // Next-state and registered-output values
   always_comb begin
      state_nxt       = state;
      owner_nxt       = owner;
      last_nxt        = last;
      gnt_nxt         = gnt;
      req_tx_done_nxt = '0;
      wr_ram_nxt      = 1'b0;
      wr_data_nxt     = '0;
      wr_addr_nxt     = '0;
      send_nxt        = 1'b0;
      size_nxt        = sendDatagramSize;
      ip_nxt          = destinationIP;
      proto_nxt       = protocolOut;
      timeout_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            gnt_nxt = '0;
            if (|req) begin
               owner_nxt = sel_c;
               gnt_nxt   = NUM_REQ'(1) << sel_c;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            if (req_wrRAM[owner]) begin
               wr_ram_nxt  = 1'b1;
               wr_data_nxt = wr_data_a[owner];
               wr_addr_nxt = wr_addr_a[owner];
            end
            // A send in the same cycle as a request drop still goes out
            if (req_sendDatagram[owner]) begin
               send_nxt  = 1'b1;
               size_nxt  = size_a[owner];
               ip_nxt    = ip_a[owner];
               proto_nxt = proto_a[owner];
               state_nxt = S_WAIT_DONE;
            end else if (!req[owner] || timeout_c) begin
               timeout_nxt = timeout_c && req[owner];
               gnt_nxt     = '0;
               state_nxt   = S_RELEASE;
            end
         end
         S_WAIT_DONE: begin
            if (tx_done_MAC) begin
               req_tx_done_nxt = NUM_REQ'(1) << owner;
               gnt_nxt         = '0;
               state_nxt       = S_RELEASE;
            end else if (timeout_c) begin
               timeout_nxt = 1'b1;
               gnt_nxt     = '0;
               state_nxt   = S_RELEASE;
            end
         end
         S_RELEASE: begin
            gnt_nxt   = '0;
            last_nxt  = owner;
            state_nxt = S_IDLE;
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: randomized scoreboard bench for udp_tx_arbiter (3 requesters, watchdog limit 100).
// Timeout expectations follow UDP_TX_ARB_TIMEOUT_EN when it is defined for the build.
module tb_udp_tx_arbiter;

   localparam int N  = 3;
   localparam int TO = 100;

   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  req_wr = '0;
   logic [N-1:0]  req_send = '0;
   logic          tx_done = 1'b0;
   logic [7:0]    d_a  [N];
   logic [10:0]   a_a  [N];
   logic [15:0]   s_a  [N];
   logic [31:0]   ip_a [N];
   logic [7:0]    p_a  [N];

   logic [8*N-1:0]  req_wrData;
   logic [11*N-1:0] req_wrAddr;
   logic [16*N-1:0] req_dgramSize;
   logic [32*N-1:0] req_destIP;
   logic [8*N-1:0]  req_protocol;

   logic [N-1:0] gnt, req_tx_done;
   logic         wrRAM, sendDatagram, arb_timeout;
   logic [7:0]   wrData, protocolOut;
   logic [10:0]  wrAddr;
   logic [15:0]  sendDatagramSize;
   logic [31:0]  destinationIP;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_wrData[8*g +: 8]     = d_a[g];
      assign req_wrAddr[11*g +: 11]   = a_a[g];
      assign req_dgramSize[16*g +: 16] = s_a[g];
      assign req_destIP[32*g +: 32]   = ip_a[g];
      assign req_protocol[8*g +: 8]   = p_a[g];
   end

   udp_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(rst), .req(req), .gnt(gnt),
      .req_wrRAM(req_wr), .req_wrData(req_wrData), .req_wrAddr(req_wrAddr),
      .req_sendDatagram(req_send), .req_dgramSize(req_dgramSize),
      .req_destIP(req_destIP), .req_protocol(req_protocol),
      .tx_done_MAC(tx_done), .req_tx_done(req_tx_done),
      .wrRAM(wrRAM), .wrData(wrData), .wrAddr(wrAddr),
      .sendDatagram(sendDatagram), .sendDatagramSize(sendDatagramSize),
      .destinationIP(destinationIP), .protocolOut(protocolOut),
      .arb_timeout(arb_timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   wr_t          wq [$];
   logic [55:0]  sq [$];
   logic [N-1:0] gq [$];
   logic [N-1:0] dq [$];
   int           last_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first requesting index after the previous owner, wrapping
   function automatic int pick(input int last, input logic [N-1:0] m);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (m[idx]) return idx;
      end
      return 0;
   endfunction

   function automatic logic [N-1:0] onehot(input int o);
      return N'(1) << o;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents an event
   int           zrun = 100;
   logic [N-1:0] gnt_prev = '0;
   logic [55:0]  cur_desc = '0;

   always @(negedge clk) begin
      if (rst) begin
         wq.delete(); sq.delete(); gq.delete(); dq.delete();
         cur_desc = '0;
         zrun     = 100;
         gnt_prev = '0;
      end else begin
         if (wrRAM) begin
            check("wr_pending", 64'(wq.size() != 0), 64'(1));
            if (wq.size() != 0) begin
               wr_t e;
               e = wq.pop_front();
               check("wr_addr_data", 64'({wrAddr, wrData}), 64'({e.addr, e.data}));
            end
         end else begin
            check("wr_idle_zero", 64'({wrAddr, wrData}), 64'(0));
         end
         if (sendDatagram) begin
            check("send_pending", 64'(sq.size() != 0), 64'(1));
            if (sq.size() != 0) cur_desc = sq.pop_front();
         end
         check("descriptor", 64'({sendDatagramSize, destinationIP, protocolOut}), 64'(cur_desc));
         if (req_tx_done != '0) begin
            check("done_pending", 64'(dq.size() != 0), 64'(1));
            if (dq.size() != 0) check("req_tx_done", 64'(req_tx_done), 64'(dq.pop_front()));
         end
         check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
         if (gnt != '0 && gnt_prev == '0) begin
            check("grant_pending", 64'(gq.size() != 0), 64'(1));
            if (gq.size() != 0) check("grant_owner", 64'(gnt), 64'(gq.pop_front()));
            check("release_gap", 64'(zrun >= 2), 64'(1));
         end
         zrun     = (gnt == '0) ? zrun + 1 : 0;
         gnt_prev = gnt;
`ifndef UDP_TX_ARB_TIMEOUT_EN
         check("arb_timeout_zero", 64'(arb_timeout), 64'(0));
`endif
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_owner(output int o, output bit ok);
      o = pick(last_m, req);
      gq.push_back(onehot(o));
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (gnt != '0) begin ok = 1'b1; break; end
      end
      if (!ok) check("grant_wait", 64'(gnt), 64'(onehot(o)));
   endtask

   // Random writes/sends from requesters that do not own the port
   task automatic noise(input int o);
      for (int i = 0; i < N; i++) begin
         if (i != o) begin
            req_wr[i]   = ($urandom_range(0, 2) == 0);
            req_send[i] = ($urandom_range(0, 7) == 0);
            d_a[i]      = ($urandom_range(0, 1) == 0) ? 8'h55 : 8'($urandom);
            a_a[i]      = ($urandom_range(0, 1) == 0) ? 11'h030 : 11'($urandom);
         end
      end
      tx_done = ($urandom_range(0, 7) == 0);
   endtask

   task automatic clear_inputs();
      req_wr   = '0;
      req_send = '0;
      tx_done  = 1'b0;
   endtask

   task automatic do_frame(input int o, input int nwr, input bit abort, input bit directed);
      for (int k = 0; k < nwr; k++) begin
         if (!directed) begin
            repeat ($urandom_range(0, 2)) begin
               noise(o);
               req_wr[o] = 1'b0;
               tick();
               clear_inputs();
            end
         end
         noise(o);
         req_wr[o] = 1'b1;
         a_a[o]    = directed ? 11'(32'h22 + 32'(k)) : 11'($urandom);
         d_a[o]    = 8'($urandom);
         wq.push_back('{addr: a_a[o], data: d_a[o]});
         if (k == nwr - 1 && !abort) begin
            req_send[o] = 1'b1;
            s_a[o]  = directed ? 16'd1292 : 16'($urandom);
            ip_a[o] = directed ? 32'h0a0105ce : $urandom;
            p_a[o]  = directed ? 8'h11 : 8'($urandom);
            sq.push_back({s_a[o], ip_a[o], p_a[o]});
         end
         tick();
         clear_inputs();
      end
      if (abort) begin
         req[o] = 1'b0;
         tick();
         check("abort_release", 64'(gnt), 64'(0));
      end else begin
         repeat ($urandom_range(1, 5)) begin
            req_wr[o] = ($urandom_range(0, 1) == 0);
            a_a[o]    = 11'($urandom);
            d_a[o]    = 8'($urandom);
            tick();
            req_wr = '0;
            check("gnt_hold", 64'(gnt), 64'(onehot(o)));
         end
         tx_done = 1'b1;
         dq.push_back(onehot(o));
         tick();
         tx_done = 1'b0;
         req[o]  = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int  o;
      bit  ok;
      int  jobs [N];
      for (int i = 0; i < N; i++) begin
         d_a[i] = '0; a_a[i] = '0; s_a[i] = '0; ip_a[i] = '0; p_a[i] = '0;
      end
      last_m = N - 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_wr", 64'({wrRAM, wrAddr, wrData}), 64'(0));
      check("rst_send", 64'(sendDatagram), 64'(0));
      check("rst_desc", 64'({sendDatagramSize, destinationIP, protocolOut}), 64'(0));
      check("rst_done", 64'(req_tx_done), 64'(0));
      check("rst_timeout", 64'(arb_timeout), 64'(0));
      rst = 1'b0;
      tick();

      // MAC done while idle is ignored
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      check("idle_done_gnt", 64'(gnt), 64'(0));

      // Directed frame: 8 bytes at 0x22..0x29, then a fixed descriptor
      req[0] = 1'b1;
      start_owner(o, ok);
      if (ok) begin
         do_frame(o, 8, 1'b0, 1'b1);
         last_m = o;
      end

      // Randomized ownership rounds with aborts
      for (int i = 0; i < N; i++) jobs[i] = $urandom_range(2, 4);
      while (ok && (jobs[0] + jobs[1] + jobs[2]) > 0) begin
         for (int i = 0; i < N; i++) if (jobs[i] > 0) req[i] = 1'b1;
         start_owner(o, ok);
         if (ok) begin
            do_frame(o, $urandom_range(1, 10), ($urandom_range(0, 3) == 0), 1'b0);
            jobs[o] = jobs[o] - 1;
            last_m  = o;
         end
      end
      tick();

      // Ownership without any MAC completion
      req = N'(1);
      start_owner(o, ok);
      if (ok) begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
         for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) check("to_before_gnt", 64'({arb_timeout, gnt}), 64'(onehot(o)));
         end
         check("to_pulse", 64'(arb_timeout), 64'(1));
         check("to_release_gnt", 64'(gnt), 64'(0));
         req = '0;
         tick();
         check("to_one_cycle", 64'(arb_timeout), 64'(0));
         last_m = o;
`else
         repeat (150) tick();
         check("hold_gnt", 64'(gnt), 64'(onehot(o)));
         check("hold_no_timeout", 64'(arb_timeout), 64'(0));
         do_frame(o, 1, 1'b0, 1'b0);
         last_m = o;
`endif
      end
      tick();

      // Reset mid-ownership returns everything to the reset state
      req = N'(1);
      start_owner(o, ok);
      if (ok) begin do_frame(o, 2, 1'b0, 1'b0); last_m = o; end
      tick();
      req = N'(2);
      start_owner(o, ok);
      if (ok) begin
         for (int k = 0; k < 3; k++) begin
            req_wr[o] = 1'b1;
            a_a[o]    = 11'($urandom);
            d_a[o]    = 8'($urandom);
            wq.push_back('{addr: a_a[o], data: d_a[o]});
            tick();
            req_wr = '0;
         end
         repeat (3) tick();
      end
      rst = 1'b1;
      #1;
      check("mid_rst_gnt", 64'(gnt), 64'(0));
      check("mid_rst_wr", 64'({wrRAM, wrAddr, wrData}), 64'(0));
      check("mid_rst_desc", 64'({sendDatagramSize, destinationIP, protocolOut}), 64'(0));
      req = '0;
      repeat (2) tick();
      rst    = 1'b0;
      last_m = N - 1;
      tick();
      req = N'(3);
      start_owner(o, ok);
      check("post_rst_owner", 64'(o), 64'(0));
      if (ok) begin do_frame(o, 3, 1'b0, 1'b0); last_m = o; end
      start_owner(o, ok);
      if (ok) begin do_frame(o, 2, 1'b0, 1'b0); last_m = o; end

      repeat (5) tick();
      check("scoreboard_drained", 64'(wq.size() + sq.size() + gq.size() + dq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
